digit_capture: RTL and testbench
================================

DIGIT_CAPTURE -- requirements
Module: digit_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical samples required before capture (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: seven_segment  input  8  display segment bus, active-low, bit7 = dp, bits[6:0] = g..a.
REQ-005 Port: anode  input  4  digit select, active-low, one-hot when a digit is driven.
REQ-006 Port: digits  output  16  captured numbers, digit k at [4k+3:4k].
REQ-007 Port: digit_valid  output  4  bit k = digit k holds a legally decoded value.
REQ-008 Port: dp  output  4  captured decimal points, active-high.
REQ-009 Port: update  output  1  one-cycle strobe: a digit value changed or became valid.
REQ-010 Port: update_idx  output  2  index of the digit reported by update; valid only while update=1.
REQ-011 Port: pattern_err  output  1  one-cycle strobe: illegal segment pattern captured.

Function
REQ-012 Inputs pass through one input register stage; all logic below operates on registered samples.
REQ-013 Legal patterns (bits[6:0]): 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9; every other pattern is illegal.
REQ-014 Decode ignores bit7 in all configurations.
REQ-015 States: IDLE, SETTLE, CAPTURED; observation = {registered anode, registered seven_segment}.
REQ-016 Registered anode not exactly one-hot-low (none or several active) -> IDLE, stability counter cleared, no capture.
REQ-017 In IDLE or CAPTURED, valid one-hot observation differing from the previous sample -> SETTLE, counter = 1.
REQ-018 In SETTLE, observation equal to the previous sample -> counter increments; observation change -> counter = 1, remain in SETTLE.
REQ-019 When counter reaches STABLE_CYCLES -> capture on that edge, state CAPTURED, counter holds.
REQ-020 Capture, legal pattern: digits[k] <= decoded value, digit_valid[k] <= 1; update=1, update_idx=k only if digit_valid[k] was 0 or the value differs.
REQ-021 Capture, illegal pattern: digits[k] unchanged, digit_valid[k] <= 0, pattern_err=1 for one cycle, update=0.
REQ-022 CAPTURED: no recapture until the observation changes; a steady display produces exactly one capture.
REQ-023 Latency: outputs reflect new steady pins after STABLE_CYCLES+1 rising edges (input register + STABLE_CYCLES samples).
REQ-024 Anode change in mid-SETTLE discards partial count; no capture for the abandoned digit.
REQ-025 update and pattern_err are never asserted in the same cycle; each is high for exactly one cycle per capture.

Reset
REQ-026 While rst_n=0 at a rising edge: digits=0, digit_valid=0, dp=0, update=0, update_idx=0, pattern_err=0, state IDLE, counter 0, input registers = seven_segment 8'hFF, anode 4'hF.
REQ-027 Reset asserted mid-SETTLE abandons the capture; first post-reset capture requires a full STABLE_CYCLES window.

Configuration
REQ-028 Macro DIGIT_CAPTURE_DP_EN defined: on every capture (legal or illegal), dp[k] <= ~seven_segment[7] sample.
REQ-029 Macro DIGIT_CAPTURE_DP_EN undefined: dp tied to 0, no dp storage flops.

Structure
REQ-030 Package seg7_pkg holds the ten segment pattern constants (shared with the segment encoder), the state enum and the digit-count constant 4.
REQ-031 Sub-module seg7_pattern_decode: combinational pattern[6:0] -> number[3:0], legal; instantiated once.

Verification
REQ-032 STABLE_CYCLES=4, anode=4'b1110, seg=8'hA4 held -> after 5 edges digits[3:0]=2, digit_valid=4'b0001, update=1 for one cycle with idx 0.
REQ-033 Same input held 20 more cycles -> no further update or pattern_err.
REQ-034 anode=4'b1011, seg=8'hFF -> after 5 edges pattern_err=1 one cycle, digit_valid[2]=0, digits[11:8] unchanged.
REQ-035 anode=4'b1101, seg=8'h99 held 3 cycles then anode=4'b0111 -> no capture on digit 1; digit 3 captured 5 edges after the switch.
REQ-036 anode=4'b1100 (two active) held 10 cycles -> state IDLE, no strobes.
REQ-037 rst_n=0 mid-SETTLE for one edge, then released with the same inputs -> all outputs zero, capture occurs 5 edges after release; with DIGIT_CAPTURE_DP_EN, seg=8'h10 gives dp[k]=1, digit 9.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for seven-segment handling: the ten legal active-low
// segment patterns (bits[6:0] = g..a, also used by the segment encoder),
// the digit-capture FSM state encoding and the number of display digits.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
// Combinational decode of an active-low seven-segment pattern into a number.
// Ports:
//   pattern_i  [6:0]  segments g..a, active-low (decimal point excluded)
//   number_o   [3:0]  decoded value 0..9 (0 when illegal)
//   legal_o           pattern is one of the ten legal digit shapes
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] number_o,
    output logic       legal_o
);

    always_comb begin
        number_o = 4'd0;
        legal_o  = 1'b1;
        case (pattern_i)
            SEG_0:   number_o = 4'd0;
            SEG_1:   number_o = 4'd1;
            SEG_2:   number_o = 4'd2;
            SEG_3:   number_o = 4'd3;
            SEG_4:   number_o = 4'd4;
            SEG_5:   number_o = 4'd5;
            SEG_6:   number_o = 4'd6;
            SEG_7:   number_o = 4'd7;
            SEG_8:   number_o = 4'd8;
            SEG_9:   number_o = 4'd9;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/digit_capture.sv
// digit_capture
// Snoops a multiplexed 4-digit seven-segment display bus and captures each
// digit once its {anode, segments} observation has been steady for
// STABLE_CYCLES consecutive samples.
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   seven_segment  [7:0]  segment bus, active-low, bit7 = dp, bits[6:0] = g..a
//   anode          [3:0]  digit select, active-low, one-hot when driving
//   digits         [15:0] captured numbers, digit k at [4k+3:4k]
//   digit_valid    [3:0]  digit k holds a legally decoded value
//   dp             [3:0]  captured decimal points, active-high
//   update                one-cycle strobe, a digit changed or became valid
//   update_idx     [1:0]  digit reported by update
//   pattern_err           one-cycle strobe, illegal pattern captured
// Build option: define DIGIT_CAPTURE_DP_EN to store decimal points; otherwise
// dp is tied low.
//
// state       | meaning
// ST_IDLE     | no single digit driven, nothing being qualified
// ST_SETTLE   | counting consecutive identical observations
// ST_CAPTURED | current observation already captured, wait for a change
module digit_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seven_segment,
    input  logic [3:0]  anode,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  dp,
    output logic        update,
    output logic [1:0]  update_idx,
    output logic        pattern_err
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [7:0]  seg_q;
    logic [3:0]  an_q;
    logic [11:0] obs_prev_q;
    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] digits_q;
    logic [3:0]  valid_q;
    logic        update_q;
    logic [1:0]  update_idx_q;
    logic        perr_q;

    logic [3:0]  an_act;
    logic        an_onehot;
    logic [1:0]  idx;
    logic [11:0] obs;
    logic        obs_same;
    logic [7:0]  cnt_inc;
    logic        stable_hit;
    logic [3:0]  dec_num;
    logic        dec_legal;
    logic [3:0]  cur_num;

    assign an_act     = ~an_q;
    // Exactly one active anode: non-zero and no second bit set.
    assign an_onehot  = (an_act != 4'd0) && ((an_act & (an_act - 4'd1)) == 4'd0);
    assign obs        = {an_q, seg_q};
    assign obs_same   = (obs == obs_prev_q);
    assign cnt_inc    = cnt_q + 8'd1;
    assign stable_hit = (cnt_inc == STABLE_CNT);
    assign cur_num    = digits_q[{idx, 2'b00} +: 4];

    always_comb begin
        idx = 2'd0;
        case (an_act)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    seg7_pattern_decode u_decode (
        .pattern_i (seg_q[6:0]),
        .number_o  (dec_num),
        .legal_o   (dec_legal)
    );

`ifdef DIGIT_CAPTURE_DP_EN
    logic [3:0] dp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_q <= 4'd0;
        end else if (an_onehot && state_q == ST_SETTLE && obs_same && stable_hit) begin
            dp_q[idx] <= ~seg_q[7];
        end
    end

    assign dp = dp_q;
`else
    assign dp = 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q        <= 8'hFF;
            an_q         <= 4'hF;
            obs_prev_q   <= {4'hF, 8'hFF};
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            digits_q     <= 16'd0;
            valid_q      <= 4'd0;
            update_q     <= 1'b0;
            update_idx_q <= 2'd0;
            perr_q       <= 1'b0;
        end else begin
            seg_q      <= seven_segment;
            an_q       <= anode;
            obs_prev_q <= obs;
            update_q   <= 1'b0;
            perr_q     <= 1'b0;

            if (!an_onehot) begin
                state_q <= ST_IDLE;
                cnt_q   <= 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= 8'd1;
                    end
                    ST_CAPTURED: begin
                        if (!obs_same) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= 8'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (!obs_same) begin
                            cnt_q <= 8'd1;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (stable_hit) begin
                                state_q <= ST_CAPTURED;
                                if (dec_legal) begin
                                    digits_q[{idx, 2'b00} +: 4] <= dec_num;
                                    valid_q[idx]                <= 1'b1;
                                    // Re-capturing an unchanged valid digit stays silent.
                                    if (!valid_q[idx] || cur_num != dec_num) begin
                                        update_q     <= 1'b1;
                                        update_idx_q <= idx;
                                    end
                                end else begin
                                    valid_q[idx] <= 1'b0;
                                    perr_q       <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign update_idx  = update_idx_q;
    assign pattern_err = perr_q;

endmodule

// File: tb/tb_digit_capture.sv
module tb_digit_capture;
    import seg7_pkg::*;

`ifdef DIGIT_CAPTURE_DP_EN
    localparam logic [3:0] EXP_DP9 = 4'b0001;
`else
    localparam logic [3:0] EXP_DP9 = 4'b0000;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  seven_segment;
    logic [3:0]  anode;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  dp;
    logic        update;
    logic [1:0]  update_idx;
    logic        pattern_err;

    int errors = 0;
    int checks = 0;
    int upd_cnt;
    int perr_cnt;
    int both_cnt;

    digit_capture #(.STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seven_segment (seven_segment),
        .anode         (anode),
        .digits        (digits),
        .digit_valid   (digit_valid),
        .dp            (dp),
        .update        (update),
        .update_idx    (update_idx),
        .pattern_err   (pattern_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n cycles, counting strobes seen after each edge.
    task automatic run(input int n);
        upd_cnt  = 0;
        perr_cnt = 0;
        both_cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (update) upd_cnt++;
            if (pattern_err) perr_cnt++;
            if (update && pattern_err) both_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        anode         = 4'hF;
        seven_segment = 8'hFF;
        tick(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        chk("rst_idx", 32'(update_idx), 32'h0);
        chk("rst_perr", 32'(pattern_err), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Digit 0 shows "2": captured after 5 edges
        rst_n = 1'b1;
        tick(1);
        anode         = 4'b1110;
        seven_segment = 8'hA4;
        tick(4);
        chk("d0_early_update", 32'(update), 32'h0);
        chk("d0_early_valid", 32'(digit_valid), 32'h0);
        tick(1);
        chk("d0_update", 32'(update), 32'h1);
        chk("d0_idx", 32'(update_idx), 32'h0);
        chk("d0_digits", 32'(digits), 32'h0002);
        chk("d0_valid", 32'(digit_valid), 32'h1);
        chk("d0_perr", 32'(pattern_err), 32'h0);
        chk("d0_dp", 32'(dp), 32'h0);
        tick(1);
        chk("d0_update_pulse", 32'(update), 32'h0);

        // Steady display: no further strobes
        run(20);
        chk("steady_updates", 32'(upd_cnt), 32'h0);
        chk("steady_perr", 32'(perr_cnt), 32'h0);
        chk("steady_digits", 32'(digits), 32'h0002);

        // Digit 2 shows "3", then an illegal pattern
        anode         = 4'b1011;
        seven_segment = 8'hB0;
        run(6);
        chk("d2_updates", 32'(upd_cnt), 32'h1);
        chk("d2_digits", 32'(digits), 32'h0302);
        chk("d2_valid", 32'(digit_valid), 32'h5);
        seven_segment = 8'hFF;
        tick(4);
        chk("ill_early_perr", 32'(pattern_err), 32'h0);
        tick(1);
        chk("ill_perr", 32'(pattern_err), 32'h1);
        chk("ill_update", 32'(update), 32'h0);
        chk("ill_valid", 32'(digit_valid), 32'h1);
        chk("ill_digits", 32'(digits), 32'h0302);
        tick(1);
        chk("ill_perr_pulse", 32'(pattern_err), 32'h0);

        // Recapture of an unchanged value on digit 0 stays silent
        anode         = 4'b1110;
        seven_segment = 8'hA4;
        run(8);
        chk("same_updates", 32'(upd_cnt), 32'h0);
        chk("same_perr", 32'(perr_cnt), 32'h0);
        chk("same_valid", 32'(digit_valid), 32'h1);
        seven_segment = 8'h99;
        tick(4);
        chk("chg_early_update", 32'(update), 32'h0);
        tick(1);
        chk("chg_update", 32'(update), 32'h1);
        chk("chg_idx", 32'(update_idx), 32'h0);
        chk("chg_digits", 32'(digits), 32'h0304);

        // Anode switches mid-settle: digit 1 abandoned, digit 3 captured
        anode = 4'b1101;
        run(3);
        chk("ab_updates", 32'(upd_cnt), 32'h0);
        anode = 4'b0111;
        run(4);
        chk("ab_sw_updates", 32'(upd_cnt), 32'h0);
        chk("ab_sw_perr", 32'(perr_cnt), 32'h0);
        chk("ab_valid_mid", 32'(digit_valid), 32'h1);
        tick(1);
        chk("d3_update", 32'(update), 32'h1);
        chk("d3_idx", 32'(update_idx), 32'h3);
        chk("d3_digits", 32'(digits), 32'h4304);
        chk("d3_valid", 32'(digit_valid), 32'h9);

        // Two anodes active: idle, no strobes
        anode = 4'b1100;
        run(10);
        chk("two_updates", 32'(upd_cnt), 32'h0);
        chk("two_perr", 32'(perr_cnt), 32'h0);
        chk("two_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("two_cnt", 32'(dut.cnt_q), 32'h0);
        chk("two_digits", 32'(digits), 32'h4304);

        // Reset mid-settle, then full window after release
        anode         = 4'b1110;
        seven_segment = 8'h10;
        tick(3);
        chk("pre_rst_state", 32'(dut.state_q), 32'(ST_SETTLE));
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mid_rst_digits", 32'(digits), 32'h0);
        chk("mid_rst_valid", 32'(digit_valid), 32'h0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        run(4);
        chk("post_rst_early", 32'(upd_cnt + perr_cnt), 32'h0);
        tick(1);
        chk("post_rst_update", 32'(update), 32'h1);
        chk("post_rst_idx", 32'(update_idx), 32'h0);
        chk("post_rst_digits", 32'(digits), 32'h0009);
        chk("post_rst_valid", 32'(digit_valid), 32'h1);
        chk("post_rst_dp", 32'(dp), 32'(EXP_DP9));
        run(1);
        chk("post_rst_pulse", 32'(upd_cnt), 32'h0);

        chk("excl_strobes", 32'(both_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
